// File: rtl/udp_echo_buffer.sv
// udp_echo_buffer: single-packet store-and-forward UDP echo stage with header swap.
// Define UDP_ECHO_DROP_CNT_EN to add o_drop_count, a saturating count of oversize packets dropped.

module udp_echo_buffer #(
    parameter int unsigned AXI_DATA_WIDTH    = 8,
    parameter int unsigned MAX_PAYLOAD       = 1472,
    parameter int unsigned SRC_PORT_OVERRIDE = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,

    input  logic                      s_udp_rx_hdr_tvalid,
    output logic                      s_udp_rx_hdr_trdy,
    input  logic [15:0]               s_udp_rx_src_port,
    input  logic [15:0]               s_udp_rx_dst_port,
    input  logic [31:0]               s_ip_rx_src_ip_addr,
    input  logic [47:0]               s_eth_rx_src_mac_addr,

    input  logic [AXI_DATA_WIDTH-1:0] s_rx_axis_tdata,
    input  logic                      s_rx_axis_tvalid,
    input  logic                      s_rx_axis_tlast,
    output logic                      s_rx_axis_trdy,

    output logic                      m_udp_tx_hdr_tvalid,
    input  logic                      m_udp_tx_hdr_trdy,
    output logic [15:0]               m_udp_tx_src_port,
    output logic [15:0]               m_udp_tx_dst_port,
    output logic [31:0]               m_ip_tx_dst_ip_addr,
    output logic [47:0]               m_eth_tx_dst_mac_addr,

    output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic                      m_tx_axis_tvalid,
    output logic                      m_tx_axis_tlast,
    input  logic                      m_tx_axis_trdy
`ifdef UDP_ECHO_DROP_CNT_EN
    ,
    output logic [15:0]               o_drop_count
`endif
);

    localparam int unsigned CNT_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned ADDR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PAYLOAD - 1);
    localparam logic [15:0]      SRC_OVR  = 16'(SRC_PORT_OVERRIDE);

    typedef enum logic [2:0] {
        IDLE,
        RX_PAY,
        DROP,
        TX_HDR,
        TX_PAY
    } state_t;

    state_t state_q, state_nxt;

    logic [AXI_DATA_WIDTH-1:0] mem [MAX_PAYLOAD];
    logic [AXI_DATA_WIDTH-1:0] ram_q;
    logic                      ram_valid_q;
    logic                      ram_last_q;

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] rd_ptr;

    logic hdr_fire;
    logic rx_fire;
    logic tx_hdr_fire;
    logic tx_fire;
    logic wr_en;
    logic pipe_active;
    logic out_load;
    logic ram_free;
    logic rd_issue;

    assign hdr_fire    = s_udp_rx_hdr_trdy & s_udp_rx_hdr_tvalid;
    assign rx_fire     = s_rx_axis_trdy & s_rx_axis_tvalid;
    assign tx_hdr_fire = m_udp_tx_hdr_tvalid & m_udp_tx_hdr_trdy;
    assign tx_fire     = m_tx_axis_tvalid & m_tx_axis_trdy;
    assign wr_en       = rx_fire & (state_q == RX_PAY);

    // Two-stage read pipeline: RAM output register feeds the output register.
    // The first byte is prefetched while the TX header waits, and the RAM stage
    // refills in the same cycle the output stage advances, giving one byte/cycle.
    always_comb begin
        pipe_active = (state_q == TX_HDR) || (state_q == TX_PAY);
        out_load    = (state_q == TX_PAY) && (!m_tx_axis_tvalid || tx_fire);
        ram_free    = !ram_valid_q || out_load;
        rd_issue    = pipe_active && ram_free && (rd_ptr < len_q);
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (hdr_fire) state_nxt = RX_PAY;
            end
            RX_PAY: begin
                if (rx_fire) begin
                    if (s_rx_axis_tlast)       state_nxt = TX_HDR;
                    else if (wr_cnt == LAST_IDX) state_nxt = DROP;
                end
            end
            DROP: begin
                if (rx_fire && s_rx_axis_tlast) state_nxt = IDLE;
            end
            TX_HDR: begin
                if (tx_hdr_fire) state_nxt = TX_PAY;
            end
            TX_PAY: begin
                if (tx_fire && m_tx_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready/valid strobes are registered from the next state so reset drives them low.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q               <= IDLE;
            s_udp_rx_hdr_trdy     <= 1'b0;
            s_rx_axis_trdy        <= 1'b0;
            m_udp_tx_hdr_tvalid   <= 1'b0;
            m_udp_tx_src_port     <= '0;
            m_udp_tx_dst_port     <= '0;
            m_ip_tx_dst_ip_addr   <= '0;
            m_eth_tx_dst_mac_addr <= '0;
            wr_cnt                <= '0;
            len_q                 <= '0;
            rd_ptr                <= '0;
            ram_valid_q           <= 1'b0;
            ram_last_q            <= 1'b0;
            m_tx_axis_tdata       <= '0;
            m_tx_axis_tvalid      <= 1'b0;
            m_tx_axis_tlast       <= 1'b0;
        end else begin
            state_q             <= state_nxt;
            s_udp_rx_hdr_trdy   <= (state_nxt == IDLE);
            s_rx_axis_trdy      <= (state_nxt == RX_PAY) || (state_nxt == DROP);
            m_udp_tx_hdr_tvalid <= (state_nxt == TX_HDR);

            if (hdr_fire) begin
                m_udp_tx_dst_port     <= s_udp_rx_src_port;
                m_udp_tx_src_port     <= (SRC_PORT_OVERRIDE == 0) ? s_udp_rx_dst_port : SRC_OVR;
                m_ip_tx_dst_ip_addr   <= s_ip_rx_src_ip_addr;
                m_eth_tx_dst_mac_addr <= s_eth_rx_src_mac_addr;
                wr_cnt                <= '0;
            end

            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (s_rx_axis_tlast) begin
                    len_q  <= wr_cnt + 1'b1;
                    rd_ptr <= '0;
                end
            end

            if (out_load) begin
                m_tx_axis_tvalid <= ram_valid_q;
                m_tx_axis_tlast  <= ram_valid_q & ram_last_q;
                if (ram_valid_q) m_tx_axis_tdata <= ram_q;
            end

            if (rd_issue) begin
                ram_valid_q <= 1'b1;
                ram_last_q  <= (rd_ptr == len_q - 1'b1);
                rd_ptr      <= rd_ptr + 1'b1;
            end else if (out_load) begin
                ram_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)    mem[wr_cnt[ADDR_W-1:0]] <= s_rx_axis_tdata;
        if (rd_issue) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end

`ifdef UDP_ECHO_DROP_CNT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_drop_count <= '0;
        end else if ((state_q == RX_PAY) && (state_nxt == DROP) && (o_drop_count != '1)) begin
            o_drop_count <= o_drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_echo_buffer.sv
// tb_udp_echo_buffer: directed + randomized checks of udp_echo_buffer against a packet-level echo model.
// Build with UDP_ECHO_DROP_CNT_EN defined to also check o_drop_count.

module tb_udp_echo_buffer;

    localparam int unsigned MAXP = 1472;
    localparam int unsigned OVR  = 0;

    typedef struct packed {
        logic [15:0] sport;
        logic [15:0] dport;
        logic [31:0] ip;
        logic [47:0] mac;
    } hdr_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        s_udp_rx_hdr_tvalid;
    logic        s_udp_rx_hdr_trdy;
    logic [15:0] s_udp_rx_src_port;
    logic [15:0] s_udp_rx_dst_port;
    logic [31:0] s_ip_rx_src_ip_addr;
    logic [47:0] s_eth_rx_src_mac_addr;
    logic [7:0]  s_rx_axis_tdata;
    logic        s_rx_axis_tvalid;
    logic        s_rx_axis_tlast;
    logic        s_rx_axis_trdy;
    logic        m_udp_tx_hdr_tvalid;
    logic        m_udp_tx_hdr_trdy;
    logic [15:0] m_udp_tx_src_port;
    logic [15:0] m_udp_tx_dst_port;
    logic [31:0] m_ip_tx_dst_ip_addr;
    logic [47:0] m_eth_tx_dst_mac_addr;
    logic [7:0]  m_tx_axis_tdata;
    logic        m_tx_axis_tvalid;
    logic        m_tx_axis_tlast;
    logic        m_tx_axis_trdy;
`ifdef UDP_ECHO_DROP_CNT_EN
    logic [15:0] o_drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int drops  = 0;
    logic [7:0] pay[$];
    logic [7:0] expq[$];
    hdr_t       exp_hdr;

    always #5 i_clk = ~i_clk;

    udp_echo_buffer #(
        .AXI_DATA_WIDTH    (8),
        .MAX_PAYLOAD       (MAXP),
        .SRC_PORT_OVERRIDE (OVR)
    ) dut (
`ifdef UDP_ECHO_DROP_CNT_EN
        .o_drop_count          (o_drop_count),
`endif
        .i_clk                 (i_clk),
        .i_reset_n             (i_reset_n),
        .s_udp_rx_hdr_tvalid   (s_udp_rx_hdr_tvalid),
        .s_udp_rx_hdr_trdy     (s_udp_rx_hdr_trdy),
        .s_udp_rx_src_port     (s_udp_rx_src_port),
        .s_udp_rx_dst_port     (s_udp_rx_dst_port),
        .s_ip_rx_src_ip_addr   (s_ip_rx_src_ip_addr),
        .s_eth_rx_src_mac_addr (s_eth_rx_src_mac_addr),
        .s_rx_axis_tdata       (s_rx_axis_tdata),
        .s_rx_axis_tvalid      (s_rx_axis_tvalid),
        .s_rx_axis_tlast       (s_rx_axis_tlast),
        .s_rx_axis_trdy        (s_rx_axis_trdy),
        .m_udp_tx_hdr_tvalid   (m_udp_tx_hdr_tvalid),
        .m_udp_tx_hdr_trdy     (m_udp_tx_hdr_trdy),
        .m_udp_tx_src_port     (m_udp_tx_src_port),
        .m_udp_tx_dst_port     (m_udp_tx_dst_port),
        .m_ip_tx_dst_ip_addr   (m_ip_tx_dst_ip_addr),
        .m_eth_tx_dst_mac_addr (m_eth_tx_dst_mac_addr),
        .m_tx_axis_tdata       (m_tx_axis_tdata),
        .m_tx_axis_tvalid      (m_tx_axis_tvalid),
        .m_tx_axis_tlast       (m_tx_axis_tlast),
        .m_tx_axis_trdy        (m_tx_axis_trdy)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the echo swaps addressing and replays payloads that fit.
    function automatic hdr_t echo_of(input hdr_t rx);
        hdr_t tx;
        tx.dport = rx.sport;
        tx.sport = (OVR == 0) ? rx.dport : 16'(OVR);
        tx.ip    = rx.ip;
        tx.mac   = rx.mac;
        return tx;
    endfunction

    task automatic model(input hdr_t h);
        exp_hdr = echo_of(h);
        expq.delete();
        if (pay.size() <= MAXP) foreach (pay[i]) expq.push_back(pay[i]);
    endtask

    function automatic hdr_t rand_hdr();
        hdr_t h;
        h.sport = 16'($urandom);
        h.dport = 16'($urandom);
        h.ip    = $urandom;
        h.mac   = 48'({$urandom, $urandom});
        return h;
    endfunction

    task automatic gen_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic drive_rx_hdr(input hdr_t h);
        s_udp_rx_src_port     = h.sport;
        s_udp_rx_dst_port     = h.dport;
        s_ip_rx_src_ip_addr   = h.ip;
        s_eth_rx_src_mac_addr = h.mac;
        s_udp_rx_hdr_tvalid   = 1'b1;
    endtask

    task automatic send_hdr(input hdr_t h);
        logic hs;
        int   to;
        drive_rx_hdr(h);
        hs = 1'b0;
        to = 0;
        while (!hs && to < 100) begin
            hs = s_udp_rx_hdr_trdy;
            tick();
            to++;
        end
        s_udp_rx_hdr_tvalid = 1'b0;
        chk("rx_hdr_accept", hs, 1);
    endtask

    task automatic send_pay(input int nsend);
        logic hs;
        int   to;
        for (int i = 0; i < nsend; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                s_rx_axis_tvalid = 1'b0;
                tick();
            end
            s_rx_axis_tdata  = pay[i];
            s_rx_axis_tvalid = 1'b1;
            s_rx_axis_tlast  = (i == pay.size() - 1);
            hs = 1'b0;
            to = 0;
            while (!hs && to < 50) begin
                hs = s_rx_axis_trdy;
                tick();
                to++;
            end
            chk("rx_beat_accept", hs, 1);
            if (!hs) break;
        end
        s_rx_axis_tvalid = 1'b0;
        s_rx_axis_tlast  = 1'b0;
    endtask

    // mode 0: trdy always 1; mode 1: trdy 1,0,1,0...; mode 2: random trdy.
    task automatic recv(input int mode, input bit offer, input hdr_t nxt);
        int         to, cyc, first, n;
        logic       pstall, plast;
        logic [7:0] pdata;
        to = 0;
        while (!m_udp_tx_hdr_tvalid && to < 50) begin
            tick();
            to++;
        end
        chk("tx_hdr_valid", m_udp_tx_hdr_tvalid, 1);
        if (!m_udp_tx_hdr_tvalid) return;
        if (offer) drive_rx_hdr(nxt);
        repeat ($urandom_range(0, 3)) tick();
        chk("tx_hdr_hold", m_udp_tx_hdr_tvalid, 1);
        chk("tx_dst_port", m_udp_tx_dst_port, exp_hdr.dport);
        chk("tx_src_port", m_udp_tx_src_port, exp_hdr.sport);
        chk("tx_dst_ip", m_ip_tx_dst_ip_addr, exp_hdr.ip);
        chk("tx_dst_mac", m_eth_tx_dst_mac_addr, exp_hdr.mac);
        m_udp_tx_hdr_trdy = 1'b1;
        tick();
        m_udp_tx_hdr_trdy = 1'b0;

        cyc    = 0;
        first  = -1;
        n      = 0;
        pstall = 1'b0;
        pdata  = '0;
        plast  = 1'b0;
        while (n < expq.size() && cyc < 4 * expq.size() + 20) begin
            case (mode)
                0:       m_tx_axis_trdy = 1'b1;
                1:       m_tx_axis_trdy = (cyc % 2 == 0);
                default: m_tx_axis_trdy = 1'($urandom_range(0, 1));
            endcase
            if (offer) chk("hdr_blocked_during_tx", s_udp_rx_hdr_trdy, 0);
            if (m_tx_axis_tvalid && first < 0) first = cyc;
            if (pstall) begin
                chk("stall_valid", m_tx_axis_tvalid, 1);
                chk("stall_data", m_tx_axis_tdata, pdata);
                chk("stall_last", m_tx_axis_tlast, plast);
            end
            if (m_tx_axis_tvalid && m_tx_axis_trdy) begin
                chk("tx_data", m_tx_axis_tdata, expq[n]);
                chk("tx_last", m_tx_axis_tlast, (n == expq.size() - 1));
                n++;
            end
            pstall = m_tx_axis_tvalid && !m_tx_axis_trdy;
            pdata  = m_tx_axis_tdata;
            plast  = m_tx_axis_tlast;
            tick();
            cyc++;
        end
        m_tx_axis_trdy = 1'b0;
        chk("tx_beats", n, expq.size());
        chk("first_valid_within_2", (first >= 0 && first <= 2), 1);
        if (mode == 0) chk("full_rate_cycles", cyc - first, expq.size());
        chk("tx_valid_after_last", m_tx_axis_tvalid, 0);
        chk("hdr_ready_after_tx", s_udp_rx_hdr_trdy, 1);
    endtask

    task automatic expect_drop();
        logic saw_tx;
        drops++;
        chk("idle_after_drop", s_udp_rx_hdr_trdy, 1);
        saw_tx = 1'b0;
        repeat (20) begin
            if (m_udp_tx_hdr_tvalid || m_tx_axis_tvalid) saw_tx = 1'b1;
            tick();
        end
        chk("no_tx_on_drop", saw_tx, 0);
`ifdef UDP_ECHO_DROP_CNT_EN
        chk("drop_count", o_drop_count, 16'(drops));
`endif
    endtask

    task automatic do_packet(input hdr_t h, input int n, input int mode);
        hdr_t none;
        none = '0;
        gen_pay(n);
        model(h);
        send_hdr(h);
        send_pay(n);
        if (n <= MAXP) recv(mode, 1'b0, none);
        else           expect_drop();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_hdr_trdy"}, s_udp_rx_hdr_trdy, 0);
        chk({tag, "_rx_trdy"}, s_rx_axis_trdy, 0);
        chk({tag, "_hdr_tvalid"}, m_udp_tx_hdr_tvalid, 0);
        chk({tag, "_tx_tvalid"}, m_tx_axis_tvalid, 0);
        chk({tag, "_tx_tlast"}, m_tx_axis_tlast, 0);
        chk({tag, "_hdr_fields"}, {m_udp_tx_src_port, m_udp_tx_dst_port}, 0);
        chk({tag, "_hdr_addr"}, {m_ip_tx_dst_ip_addr, m_eth_tx_dst_mac_addr}, 0);
`ifdef UDP_ECHO_DROP_CNT_EN
        chk({tag, "_drop_count"}, o_drop_count, 0);
`endif
    endtask

    initial begin
        hdr_t h, h2, none;
        none                  = '0;
        i_reset_n             = 1'b0;
        s_udp_rx_hdr_tvalid   = 1'b0;
        s_udp_rx_src_port     = '0;
        s_udp_rx_dst_port     = '0;
        s_ip_rx_src_ip_addr   = '0;
        s_eth_rx_src_mac_addr = '0;
        s_rx_axis_tdata       = '0;
        s_rx_axis_tvalid      = 1'b0;
        s_rx_axis_tlast       = 1'b0;
        m_udp_tx_hdr_trdy     = 1'b0;
        m_tx_axis_trdy        = 1'b0;

        tick();
        tick();
        check_outputs_zero("reset");
        i_reset_n = 1'b1;
        tick();
        tick();
        chk("idle_hdr_ready", s_udp_rx_hdr_trdy, 1);
        chk("idle_rx_not_ready", s_rx_axis_trdy, 0);

        // 10-byte known packet, ports 0x1234 -> 0x0050
        h       = rand_hdr();
        h.sport = 16'h1234;
        h.dport = 16'h0050;
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'(i));
        model(h);
        chk("model_swap_dst", exp_hdr.dport, 16'h1234);
        send_hdr(h);
        send_pay(10);
        recv(0, 1'b0, none);

        do_packet(rand_hdr(), 1, 0);
        do_packet(rand_hdr(), 64, 1);
        for (int k = 0; k < 6; k++) do_packet(rand_hdr(), int'($urandom_range(1, 200)), int'($urandom_range(0, 2)));

        do_packet(rand_hdr(), MAXP + 1, 0);
        do_packet(rand_hdr(), MAXP, 0);

        // second header offered while the first packet is still echoing
        h  = rand_hdr();
        h2 = rand_hdr();
        gen_pay(20);
        model(h);
        send_hdr(h);
        send_pay(20);
        recv(2, 1'b1, h2);
        tick();
        s_udp_rx_hdr_tvalid = 1'b0;
        chk("second_hdr_taken", s_rx_axis_trdy, 1);
        gen_pay(15);
        model(h2);
        send_pay(15);
        recv(0, 1'b0, none);

        // reset in the middle of receiving a payload
        h = rand_hdr();
        h.sport = h.sport | 16'h0001;
        gen_pay(12);
        send_hdr(h);
        send_pay(5);
        i_reset_n = 1'b0;
        #1;
        check_outputs_zero("midpkt_reset");
        drops = 0;
        tick();
        i_reset_n = 1'b1;
        repeat (5) tick();
        chk("no_partial_tx", m_udp_tx_hdr_tvalid, 0);
        do_packet(rand_hdr(), 8, 2);

        do_packet(rand_hdr(), MAXP + 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_echo_buffer.md
UDP_ECHO_BUFFER -- requirements
Module: udp_echo_buffer

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 8, payload byte width; only 8 is supported.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1472, payload buffer depth in bytes.
REQ-003 SHALL have parameter SRC_PORT_OVERRIDE, default 0; 0 uses the echoed received dst port as the TX src port, otherwise this value.
REQ-004 SHALL provide ports (name  direction  width  meaning):
- i_clk  in  1  single clock; all logic is on its rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- s_udp_rx_hdr_tvalid  in  1  RX UDP/IP header valid.
- s_udp_rx_hdr_trdy  out  1  RX header ready.
- s_udp_rx_src_port  in  16  received source port.
- s_udp_rx_dst_port  in  16  received destination port.
- s_ip_rx_src_ip_addr  in  32  received source IP.
- s_eth_rx_src_mac_addr  in  48  received source MAC.
- s_rx_axis_tdata  in  8  RX payload byte.
- s_rx_axis_tvalid  in  1  RX payload valid.
- s_rx_axis_tlast  in  1  RX last payload byte.
- s_rx_axis_trdy  out  1  RX payload ready.
- m_udp_tx_hdr_tvalid  out  1  TX header valid.
- m_udp_tx_hdr_trdy  in  1  TX header ready.
- m_udp_tx_src_port  out  16  TX source port.
- m_udp_tx_dst_port  out  16  TX destination port (received src port).
- m_ip_tx_dst_ip_addr  out  32  TX destination IP (received src IP).
- m_eth_tx_dst_mac_addr  out  48  TX destination MAC (received src MAC).
- m_tx_axis_tdata  out  8  TX payload byte.
- m_tx_axis_tvalid  out  1  TX payload valid.
- m_tx_axis_tlast  out  1  TX last payload byte.
- m_tx_axis_trdy  in  1  TX payload ready.

Function
REQ-005 SHALL be a single-packet store-and-forward echo stage with FSM states IDLE, RX_PAY, DROP, TX_HDR, TX_PAY.
REQ-006 IDLE: s_udp_rx_hdr_trdy=1 and all other ready/valid outputs 0; on hdr handshake, SHALL latch the swapped header fields, clear wr_cnt, and go to RX_PAY.
REQ-007 RX_PAY: s_rx_axis_trdy=1; each beat SHALL write tdata to buffer[wr_cnt] and increment wr_cnt.
REQ-008 RX_PAY: on a tlast beat with wr_cnt < MAX_PAYLOAD, SHALL store len=wr_cnt+1 and go to TX_HDR.
REQ-009 RX_PAY: a non-tlast beat accepted at wr_cnt=MAX_PAYLOAD-1 SHALL go to DROP; a tlast beat at that index is legal (exactly MAX_PAYLOAD bytes).
REQ-010 DROP: s_rx_axis_trdy=1, no writes; the tlast beat SHALL return to IDLE with no TX activity.
REQ-011 TX_HDR: m_udp_tx_hdr_tvalid=1 with fields stable; the handshake SHALL go to TX_PAY; a deasserted trdy SHALL hold indefinitely.
REQ-012 TX_PAY: SHALL present buffer bytes 0..len-1 in order with m_tx_axis_tlast=1 only on byte len-1.
REQ-013 TX_PAY: tdata/tvalid SHALL stay stable while trdy=0 (registered RAM read with prefetch); the first tvalid SHALL occur at most 2 cycles after TX header handshake.
REQ-014 TX_PAY: full rate SHALL be sustained (one byte/cycle while trdy=1); the final handshake SHALL go to IDLE.
REQ-015 No RX header or payload SHALL be accepted outside IDLE/RX_PAY/DROP (backpressure upstream).
REQ-016 Counters SHALL be clog2(MAX_PAYLOAD+1) bits wide and SHALL never wrap.
REQ-017 Buffer SHALL infer block RAM (one write port, one registered read port).

Reset
REQ-018 i_reset_n=0 SHALL asynchronously force IDLE, counters 0, all valid/ready/tlast outputs 0, and header outputs 0; buffer contents are not reset.
REQ-019 Reset mid-packet SHALL abandon the packet; after release, no partial TX SHALL occur.

Configuration
REQ-020 Macro UDP_ECHO_DROP_CNT_EN defined: SHALL add output o_drop_count (16 bits), incremented once per packet entering DROP, saturating at 16'hFFFF, reset to 0; undefined: port and counter absent, behaviour otherwise identical.

Verification
REQ-021 10-byte payload 0x00..0x09, src port 0x1234, dst port 0x0050 -> TX header dst 0x1234, src 0x0050 (SRC_PORT_OVERRIDE=0), payload 0x00..0x09, tlast on byte 10.
REQ-022 TX trdy toggled 1-0 each cycle on a 64-byte packet -> identical bytes, data stable during stalls, exactly 64 handshakes.
REQ-023 1473-byte packet (MAX_PAYLOAD=1472) -> no TX header, all bytes consumed, IDLE after tlast, o_drop_count=1 when enabled.
REQ-024 Exactly-1472-byte packet -> full echo with tlast on byte 1472; 1-byte packet -> single beat with tlast=1.
REQ-025 Second header offered during TX_PAY -> s_udp_rx_hdr_trdy=0 until first packet completes, then accepted.
REQ-026 i_reset_n pulsed low at byte 5 of RX -> outputs 0 immediately; next 8-byte packet echoed correctly.
